// File: rtl/mips_prog_loader.sv
// mips_prog_loader: host-side command front-end for a small MIPS core.
// It accepts one host command at a time (memory write, run, register read),
// drives the instruction/data memory, register-file read port or CPU
// run/init controls, and returns exactly one response per command.
// Optional build macro LOADER_READBACK_VERIFY_EN adds a read-back compare
// cycle after every memory write.
module mips_prog_loader #(
  parameter int MEM_AW      = 10,
  parameter int RUN_TIMEOUT = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [MEM_AW-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [4:0]        reg_addr,
  input  logic [31:0]       reg_rdata,
  output logic              cpu_init,
  output logic              cpu_run,
  input  logic              cpu_halted
);

  localparam logic [31:0] TIMEOUT_W = 32'(RUN_TIMEOUT);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_REGRD = 2'b10;

`ifdef LOADER_READBACK_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE, WRITE, VERIFY, REG_RD, INIT, RUN, RESP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WRITE, REG_RD, INIT, RUN, RESP
  } state_t;

  // Read data has no consumer when read-back verification is not built in.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  state_t             state_q, state_d;
  logic [MEM_AW-1:0]  addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  // State and command/response registers; reset discards anything in flight.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      count_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      count_q    <= count_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state logic: command decode, run-cycle counting, response capture.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    count_d    = count_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d     = cmd_addr;
          data_d     = cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          case (cmd_op)
            OP_WRITE: state_d = WRITE;
            OP_RUN:   state_d = INIT;
            OP_REGRD: state_d = REG_RD;
            default: begin
              rsp_err_d = 1'b1;
              state_d   = RESP;
            end
          endcase
        end
      end
      WRITE: begin
`ifdef LOADER_READBACK_VERIFY_EN
        state_d = VERIFY;
`else
        state_d = RESP;
`endif
      end
`ifdef LOADER_READBACK_VERIFY_EN
      VERIFY: begin
        // Memory now holds the word written last cycle; any difference is reported.
        if (mem_rdata != data_q) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = mem_rdata;
        end
        state_d = RESP;
      end
`endif
      REG_RD: begin
        // Indices beyond the 32-entry register file are rejected.
        if (addr_q[MEM_AW-1:5] != '0) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else begin
          rsp_data_d = reg_rdata;
        end
        state_d = RESP;
      end
      INIT: begin
        count_d = 32'd1;
        state_d = RUN;
      end
      RUN: begin
        // A halt seen on the timeout cycle still counts as a clean halt.
        if (cpu_halted) begin
          rsp_data_d = count_q;
          state_d    = RESP;
        end else if (count_q == TIMEOUT_W) begin
          rsp_data_d = TIMEOUT_W;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: every strobe is a pure function of the current state.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_data  = rsp_data_q;
    rsp_err   = rsp_err_q;
    mem_we    = (state_q == WRITE);
    mem_wdata = (state_q == WRITE) ? data_q : '0;
`ifdef LOADER_READBACK_VERIFY_EN
    mem_addr  = (state_q == WRITE || state_q == VERIFY) ? addr_q : '0;
`else
    mem_addr  = (state_q == WRITE) ? addr_q : '0;
`endif
    reg_addr  = (state_q == REG_RD) ? addr_q[4:0] : '0;
    cpu_init  = (state_q == INIT);
    cpu_run   = (state_q == RUN);
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Testbench for mips_prog_loader: random and directed host commands checked
// against a behavioural model of memory, register file and a toy CPU.
module tb_mips_prog_loader;

  localparam int AW = 10;
  localparam int TO = 16;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [4:0]    reg_addr;
  logic [31:0]   reg_rdata;
  logic          cpu_init;
  logic          cpu_run;
  logic          cpu_halted;

  mips_prog_loader #(.MEM_AW(AW), .RUN_TIMEOUT(TO)) dut (
    .clk1(clk1), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata),
    .cpu_init(cpu_init), .cpu_run(cpu_run), .cpu_halted(cpu_halted)
  );

  always #5 clk1 = ~clk1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Environment models: memory, register file, toy CPU, activity monitors.
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] regfile [0:31];
  bit          force_bad = 0;
  int          halt_n = 0;     // 0: never halt; N>=2: halted sampled in run cycle N
  int          cpu_cnt = 0;
  int          we_cnt = 0, init_cnt = 0, run_cyc = 0;
  logic [AW-1:0] last_waddr;
  logic [31:0]   last_wdata;

  assign mem_rdata = force_bad ? 32'hdeadbeef : mem[mem_addr];
  assign reg_rdata = regfile[reg_addr];

  always @(posedge clk1 or posedge rst) begin
    if (rst) begin
      cpu_halted <= 1'b0;
      cpu_cnt    <= 0;
    end else if (cpu_init) begin
      cpu_halted <= 1'b0;
      cpu_cnt    <= 0;
    end else if (cpu_run) begin
      cpu_cnt <= cpu_cnt + 1;
      if (halt_n >= 2 && cpu_cnt + 1 == halt_n - 1) cpu_halted <= 1'b1;
    end
  end

  always @(posedge clk1) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt++;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (cpu_init) init_cnt++;
    if (cpu_run) run_cyc++;
  end

  // Issue one command, optionally stall the response, return its payload.
  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [31:0] data, input int hold,
                        output logic [31:0] rd, output logic re);
    int t;
    logic [31:0] d0;
    logic e0;
    rd = '0;
    re = 1'b0;
    @(negedge clk1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk1); t++; end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk1);
    cmd_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk1); t++; end
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
      return;
    end
    d0 = rsp_data;
    e0 = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk1);
      chk("hold_data", rsp_data, d0);
      chk("hold_err", 32'(rsp_err), 32'(e0));
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rd = rsp_data;
    re = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk1);
    rsp_ready = 1'b0;
    chk("rsp_gap", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic        re;
  int          w0, i0, r0;

  task automatic write_and_check(input logic [AW-1:0] a, input logic [31:0] d);
    w0 = we_cnt;
    do_cmd(2'b00, a, d, 0, rd, re);
    chk("wr_pulses", 32'(we_cnt - w0), 32'd1);
    chk("wr_addr", 32'(last_waddr), 32'(a));
    chk("wr_data", last_wdata, d);
    chk("wr_rsp_data", rd, 32'd0);
    chk("wr_rsp_err", 32'(re), 32'd0);
  endtask

  task automatic run_and_check(input int hn);
    int exp_cyc;
    bit exp_err;
    halt_n = hn;
    exp_err = !(hn >= 2 && hn <= TO);
    exp_cyc = exp_err ? TO : hn;
    i0 = init_cnt;
    r0 = run_cyc;
    do_cmd(2'b01, '0, '0, 0, rd, re);
    chk("run_rsp_data", rd, 32'(exp_cyc));
    chk("run_rsp_err", 32'(re), 32'(exp_err));
    chk("run_init_pulses", 32'(init_cnt - i0), 32'd1);
    chk("run_cycles", 32'(run_cyc - r0), 32'(exp_cyc));
    chk("run_low_after", 32'(cpu_run), 32'd0);
  endtask

  task automatic regrd_and_check(input logic [AW-1:0] a);
    bit bad;
    bad = (a[AW-1:5] != '0);
    do_cmd(2'b10, a, '0, 0, rd, re);
    chk("reg_rsp_err", 32'(re), 32'(bad));
    chk("reg_rsp_data", rd, bad ? 32'd0 : regfile[a[4:0]]);
  endtask

  logic [31:0] prog [0:7];
  int seen;

  initial begin
    prog[0] = 32'h2001000a; prog[1] = 32'h20020014; prog[2] = 32'h00221820;
    prog[3] = 32'h20630001; prog[4] = 32'h00632020; prog[5] = 32'h2084ffff;
    prog[6] = 32'h00000000; prog[7] = 32'hfc000000;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    regfile[5] = 32'd55;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk1);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_outs", {26'd0, mem_we, cpu_init, cpu_run, rsp_err, |mem_addr, |reg_addr}, 32'd0);
    rst = 1'b0;

    // Directed writes, then a full program load and a halting run.
    write_and_check(10'd0, 32'h2801000a);
    write_and_check(10'd8, 32'hfc000000);
    for (int i = 0; i < 8; i++) write_and_check(AW'(i), prog[i]);
    for (int i = 0; i < 8; i++) chk("prog_mem", mem[i], prog[i]);
    run_and_check(12);
    run_and_check(0);
    run_and_check(TO);
    run_and_check(TO + 1);

    // Register reads and illegal op.
    regrd_and_check(10'd5);
    regrd_and_check(10'h25);
    w0 = we_cnt; i0 = init_cnt; r0 = run_cyc;
    do_cmd(2'b11, 10'd3, 32'h12345678, 0, rd, re);
    chk("ill_err", 32'(re), 32'd1);
    chk("ill_data", rd, 32'd0);
    chk("ill_side", 32'((we_cnt - w0) + (init_cnt - i0) + (run_cyc - r0)), 32'd0);

    // Stalled response.
    do_cmd(2'b10, 10'd5, '0, 10, rd, re);
    chk("stall_data", rd, 32'd55);

    // Randomised mix of commands.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: write_and_check(AW'($urandom), $urandom);
        1: run_and_check(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, TO + 4)));
        2: regrd_and_check(($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom));
        default: begin
          w0 = we_cnt; i0 = init_cnt; r0 = run_cyc;
          do_cmd(2'b11, AW'($urandom), $urandom, 0, rd, re);
          chk("rnd_ill_err", 32'(re), 32'd1);
          chk("rnd_ill_side", 32'((we_cnt - w0) + (init_cnt - i0) + (run_cyc - r0)), 32'd0);
        end
      endcase
    end

`ifdef LOADER_READBACK_VERIFY_EN
    force_bad = 1;
    do_cmd(2'b00, 10'd20, 32'h1, 0, rd, re);
    force_bad = 0;
    chk("vfy_err", 32'(re), 32'd1);
    chk("vfy_data", rd, 32'hdeadbeef);
`endif

    // Reset in the middle of a run: cpu_run must fall without a clock edge.
    halt_n = 0;
    @(negedge clk1);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = '0; cmd_data = '0;
    @(negedge clk1);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk1);
    chk("mid_run_active", 32'(cpu_run), 32'd1);
    #1 rst = 1'b1;
    #1 chk("rst_async_run", 32'(cpu_run), 32'd0);
    chk("rst_async_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (TO + 8) begin
      @(negedge clk1);
      if (rsp_valid || cpu_run) seen++;
    end
    rsp_ready = 1'b0;
    chk("rst_no_rsp", 32'(seen), 32'd0);

    // Loader still usable after reset.
    regrd_and_check(10'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_prog_loader.md
MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 Parameter MEM_AW, default 10: instruction/data memory word-address width.
REQ-002 Parameter RUN_TIMEOUT, default 1024: maximum run cycles before abort.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk1  in  1  sole clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command accepted when both high.
- cmd_op  in  2  00 mem write; 01 run; 10 reg read; 11 illegal.
- cmd_addr  in  MEM_AW  memory word address or register index.
- cmd_data  in  32  memory write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  32  response payload.
- rsp_err  out  1  response error flag.
- mem_we  out  1  memory write strobe.
- mem_addr  out  MEM_AW  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, combinational from mem_addr.
- reg_addr  out  5  register-file read index.
- reg_rdata  in  32  register-file data, combinational from reg_addr.
- cpu_init  out  1  one-cycle pulse clearing CPU HALTED and Branch_Taken.
- cpu_run  out  1  level; CPU pipeline advances only while high.
- cpu_halted  in  1  CPU HALTED flag.

Function
REQ-004 FSM states SHALL be IDLE, WRITE, VERIFY (macro only), REG_RD, INIT, RUN, RESP.
REQ-005 cmd_ready SHALL be high only in IDLE; exactly one command is accepted per handshake.
REQ-006 Every accepted command SHALL produce exactly one response, in order, before the next command is accepted.
REQ-007 Op 00: IDLE->WRITE; WRITE drives mem_we=1, mem_addr=cmd_addr, mem_wdata=cmd_data for exactly one cycle, then ->RESP with rsp_data=0, rsp_err=0.
REQ-008 Op 10: IDLE->REG_RD; reg_addr=cmd_addr[4:0]; reg_rdata captured at end of REG_RD; ->RESP with rsp_data=captured value; rsp_err=1 and rsp_data=0 if cmd_addr[MEM_AW-1:5] is nonzero.
REQ-009 Op 01: IDLE->INIT (cpu_init=1 for one cycle, cpu_run=0) ->RUN; cpu_run=1 throughout RUN.
REQ-010 In RUN a 32-bit cycle counter SHALL start at 1 and increment each cycle; cpu_halted sampled high exits to RESP with rsp_data=count, rsp_err=0.
REQ-011 If count reaches RUN_TIMEOUT without cpu_halted, RUN SHALL exit to RESP with rsp_data=RUN_TIMEOUT, rsp_err=1.
REQ-012 cpu_halted and timeout in the same cycle SHALL report halted (rsp_err=0).
REQ-013 cpu_run SHALL be low in every state other than RUN, including the RESP cycle that follows RUN.
REQ-014 Op 11: ->RESP with rsp_err=1, rsp_data=0, no memory, register, or CPU activity.
REQ-015 RESP SHALL hold rsp_valid, rsp_data, and rsp_err stable until rsp_ready is high, then ->IDLE; back-to-back responses SHALL be impossible (at least one IDLE cycle between them).
REQ-016 mem_we and cpu_init SHALL never be high outside WRITE and INIT respectively.

Reset
REQ-017 rst high SHALL immediately force IDLE, cmd_ready=1, and all other outputs and counters to 0, including mid-RUN (cpu_run drops asynchronously).
REQ-018 A command or response in flight at reset SHALL be discarded without a response.

Configuration
REQ-019 Macro LOADER_READBACK_VERIFY_EN: when defined, WRITE->VERIFY; VERIFY holds mem_addr and compares mem_rdata with the written word; on mismatch, rsp_err=1 and rsp_data=mem_rdata, else rsp_err=0 and rsp_data=0; adds one cycle of latency.
REQ-020 Without LOADER_READBACK_VERIFY_EN: no VERIFY state; mem_rdata is ignored; write response per REQ-007.

Verification
REQ-021 Write 0x2801000a to addr 0, then 0xfc000000 to addr 8 -> one mem_we pulse each, with correct addr/data; two responses, err=0.
REQ-022 Load the eight-instruction ADDI/ADD/HLT program, then run with a model CPU raising cpu_halted after 12 cycles -> single cpu_init pulse, cpu_run high 12 cycles, rsp_data=12, err=0.
REQ-023 Run with cpu_halted held low, RUN_TIMEOUT=16 -> cpu_run low after 16 cycles, rsp_data=16, err=1.
REQ-024 Reg read index 5 with reg_rdata=55 -> rsp_data=55; index 0x25 -> err=1, rsp_data=0; op 11 -> err=1, no side effects.
REQ-025 Hold rsp_ready low 10 cycles -> response stable, cmd_ready low; assert rst mid-RUN -> cpu_run falls without a clock edge, no response.
REQ-026 With LOADER_READBACK_VERIFY_EN, force mem_rdata=0xdeadbeef after a write of 0x1 -> err=1, rsp_data=0xdeadbeef.
